neopixel_strand_ctrl_param: RTL

//  Parametrised NeoPixel (WS2812/SK6812) strand controller. Holds a per-pixel colour buffer,

---
 rtl/neopixel_pkg.sv | 39 +++
 rtl/neopixel_bit_encoder.sv | 53 +++++
 rtl/neopixel_strand_ctrl_param.sv | 132 +++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// Shared types, default timing and the wire byte-order helper for the
// NeoPixel strand controller.
package neopixel_pkg;

  typedef enum logic [1:0] {
    COLOR_R = 2'd0,
    COLOR_B = 2'd1,
    COLOR_G = 2'd2,
    COLOR_W = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_LATCH
  } state_e;

  localparam int DEFAULT_NUM_PIXELS   = 8;
  localparam int DEFAULT_CHANNELS     = 3;
  localparam int DEFAULT_BIT_CYCLES   = 62;
  localparam int DEFAULT_T0H_CYCLES   = 18;
  localparam int DEFAULT_T1H_CYCLES   = 35;
  localparam int DEFAULT_LATCH_CYCLES = 2500;

  // Bytes leave the wire as G,R,B,W while the buffer is addressed R,B,G,W.
  function automatic color_e wire_color(input logic [1:0] byte_pos);
    case (byte_pos)
      2'd0:    wire_color = COLOR_G;
      2'd1:    wire_color = COLOR_R;
      2'd2:    wire_color = COLOR_B;
      default: wire_color = COLOR_W;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Produces one NeoPixel bit cell per start pulse; the bit value is read
// only once the common '0' high time has elapsed.
module neopixel_bit_encoder
  import neopixel_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int T0H_CYCLES = DEFAULT_T0H_CYCLES,
  parameter int T1H_CYCLES = DEFAULT_T1H_CYCLES,
  parameter int CW         = 12
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic bit_val,
  output logic waveform,
  output logic bit_done
);

  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] cnt_inc;
  logic          active;

  assign cnt_inc  = cycle_cnt + CW'(1);
  assign bit_done = active && (cycle_cnt == CW'(BIT_CYCLES - 1));

  function automatic logic level(input logic [CW-1:0] c, input logic b);
    if (c < CW'(T0H_CYCLES))      level = 1'b1;
    else if (c < CW'(T1H_CYCLES)) level = b;
    else                          level = 1'b0;
  endfunction

  // Registered waveform keeps the data line glitch-free; a start on the
  // final cycle of a bit chains the next cell with no gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      active    <= 1'b0;
      waveform  <= 1'b0;
    end else if (start) begin
      cycle_cnt <= '0;
      active    <= 1'b1;
      waveform  <= 1'b1;
    end else if (bit_done) begin
      cycle_cnt <= '0;
      active    <= 1'b0;
      waveform  <= 1'b0;
    end else if (active) begin
      cycle_cnt <= cnt_inc;
      waveform  <= level(cnt_inc, bit_val);
    end
  end

endmodule

// File: rtl/neopixel_strand_ctrl_param.sv
// Parametrised WS2812/SK6812 strand controller: colour buffer, frame FSM and
// pixel/bit sequencing around the per-bit encoder.
module neopixel_strand_ctrl_param
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS   = DEFAULT_NUM_PIXELS,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int BIT_CYCLES   = DEFAULT_BIT_CYCLES,
  parameter int T0H_CYCLES   = DEFAULT_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEFAULT_T1H_CYCLES,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  localparam int PW          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_color,
  input  logic [PW-1:0] pixel_index,
  input  logic [1:0]    color_index,
  input  logic [7:0]    color_level,
  input  logic          send_it,
  output logic          neo_data,
  output logic          ready_to_load,
  output logic          ready_to_send,
  output logic          load_err,
  output logic          frame_done
);

  localparam int BITS_PER_PIXEL = CHANNELS * 8;
  localparam int BW = $clog2(BITS_PER_PIXEL);
  localparam int CW = $clog2(max_int(BIT_CYCLES, LATCH_CYCLES) + 1);

  if (CHANNELS != 3 && CHANNELS != 4) begin : g_bad_channels
    $fatal(1, "CHANNELS must be 3 or 4");
  end
  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $fatal(1, "bit timing must satisfy 0 < T0H < T1H < BIT_CYCLES");
  end
  if (NUM_PIXELS < 1 || LATCH_CYCLES < 1) begin : g_bad_size
    $fatal(1, "NUM_PIXELS and LATCH_CYCLES must be at least 1");
  end

  state_e        state, state_next;
  logic [7:0]    buffer [NUM_PIXELS][CHANNELS];
  logic [PW-1:0] pixel_cnt;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] latch_cnt;
  logic          enc_start, enc_bit, bit_done;
  logic          load_ok, last_bit, latch_end;

  assign load_ok   = load_color && (state == ST_IDLE) &&
                     (int'(pixel_index) < NUM_PIXELS) && (int'(color_index) < CHANNELS);
  assign last_bit  = (pixel_cnt == PW'(NUM_PIXELS - 1)) && (bit_cnt == BW'(BITS_PER_PIXEL - 1));
  assign latch_end = (state == ST_LATCH) && (latch_cnt == CW'(LATCH_CYCLES - 1));

  // Counters always address the bit currently on the wire.
  assign enc_bit = buffer[pixel_cnt][wire_color(bit_cnt[BW-1:3])][3'd7 - bit_cnt[2:0]];

  assign ready_to_load = (state == ST_IDLE);
  assign ready_to_send = (state == ST_IDLE);

  always_comb begin
    state_next = state;
    enc_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (send_it) begin
          state_next = ST_SEND;
          enc_start  = 1'b1;
        end
      end
      ST_SEND: begin
        if (bit_done) begin
          if (last_bit) state_next = ST_LATCH;
          else          enc_start  = 1'b1;
        end
      end
      ST_LATCH: begin
        if (latch_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pixel_cnt  <= '0;
      bit_cnt    <= '0;
      latch_cnt  <= '0;
      load_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      load_err   <= load_color && !load_ok;
      frame_done <= latch_end;
      if (state == ST_SEND && bit_done) begin
        if (bit_cnt == BW'(BITS_PER_PIXEL - 1)) begin
          bit_cnt   <= '0;
          pixel_cnt <= (pixel_cnt == PW'(NUM_PIXELS - 1)) ? '0 : pixel_cnt + PW'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      if (state == ST_LATCH) latch_cnt <= latch_end ? '0 : latch_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < CHANNELS; c++)
          buffer[p][c] <= 8'h00;
    end else if (load_ok) begin
      buffer[pixel_index][color_index] <= color_level;
    end
  end

  neopixel_bit_encoder #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .CW        (CW)
  ) u_encoder (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (enc_start),
    .bit_val (enc_bit),
    .waveform(neo_data),
    .bit_done(bit_done)
  );

endmodule
